adder_cla_4bit: RTL and testbench

- 4-bit carry-lookahead adder: a + b + cin -> 4-bit sum, carry out, two's-complement overflow flag.
- Arithmetic outputs are purely combinational (zero latency).
- A registered copy of all results is provided for pipelined consumers.
- Leaf arithmetic block; building block for wider CLA adders (e.g. 16-bit via cascaded cout -> cin).

---
 rtl/adder_cla_4bit_pkg.sv | 15 +
 rtl/adder_cla_4bit_if.sv | 26 ++
 rtl/adder_cla_4bit_full_adder_bit.sv | 19 +
 rtl/adder_cla_4bit_lookahead.sv | 34 +++
 rtl/adder_cla_4bit.sv | 67 ++++++
 tb/tb_adder_cla_4bit.sv | 129 ++++++++++++
 6 files changed

// File: rtl/adder_cla_4bit_pkg.sv
// Shared width, operand type and result bundle for the 4-bit carry-lookahead adder.
// The result struct lets the output register stage be handled as one value.
package adder_cla_4bit_pkg;

  localparam int unsigned WIDTH = 4;

  typedef logic [WIDTH-1:0] nibble_t;

  typedef struct packed {
    nibble_t s;
    logic    cout;
    logic    ovfl;
  } result_t;

endpackage

// File: rtl/adder_cla_4bit_if.sv
// Operand/result bundle of the 4-bit CLA adder: combinational results plus their registered copies.
// The master drives the operands; the slave (the adder) drives every result.
interface adder_cla_4bit_if;
  import adder_cla_4bit_pkg::*;

  nibble_t a;
  nibble_t b;
  logic    cin;
  nibble_t s;
  logic    cout;
  logic    ovfl;
  nibble_t s_q;
  logic    cout_q;
  logic    ovfl_q;

  modport master (
    output a, b, cin,
    input  s, cout, ovfl, s_q, cout_q, ovfl_q
  );

  modport slave (
    input  a, b, cin,
    output s, cout, ovfl, s_q, cout_q, ovfl_q
  );

endinterface

// File: rtl/adder_cla_4bit_full_adder_bit.sv
// One bit slice of the CLA adder: two half-adder stages producing generate, propagate and sum.
// The slice never forms its own carry out; carries come only from the lookahead unit.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic g_o,
  output logic p_o
);

  // First half adder: operand bits give generate (carry) and propagate (sum).
  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;

  // Second half adder: its sum is the bit result.
  assign s_o = p_o ^ c_i;

endmodule

// File: rtl/adder_cla_4bit_lookahead.sv
// Two-level carry-lookahead unit for a 4-bit group: every carry is a flat sum of products.
// Group generate/propagate let a higher-level lookahead treat this block as a single digit.
module cla_lookahead_4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       cin_i,
  output logic [4:1] c_o,
  output logic       g_grp_o,
  output logic       p_grp_o
);

  assign c_o[1] = g_i[0]
                | (p_i[0] & cin_i);

  assign c_o[2] = g_i[1]
                | (p_i[1] & g_i[0])
                | (p_i[1] & p_i[0] & cin_i);

  assign c_o[3] = g_i[2]
                | (p_i[2] & g_i[1])
                | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & cin_i);

  // Group generate is c4 with the carry-in term dropped.
  assign g_grp_o = g_i[3]
                 | (p_i[3] & g_i[2])
                 | (p_i[3] & p_i[2] & g_i[1])
                 | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

  assign p_grp_o = &p_i;

  assign c_o[4] = g_grp_o | (p_grp_o & cin_i);

endmodule

// File: rtl/adder_cla_4bit.sv
// 4-bit carry-lookahead adder with zero-latency results and a one-cycle registered copy.
// Cascade wider adders by chaining cout into the next block's cin.
module adder_cla_4bit
  import adder_cla_4bit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  adder_cla_4bit_if.slave    bus
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             g_grp;
  logic             p_grp;
  result_t          res_d;
  result_t          res_q;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_fa (
      .a_i (bus.a[i]),
      .b_i (bus.b[i]),
      .c_i (c[i]),
      .s_o (sum[i]),
      .g_o (g[i]),
      .p_o (p[i])
    );
  end

  cla_lookahead_4 u_cla (
    .g_i     (g),
    .p_i     (p),
    .cin_i   (bus.cin),
    .c_o     (c[WIDTH:1]),
    .g_grp_o (g_grp),
    .p_grp_o (p_grp)
  );

  // Signed overflow: carry into the sign bit differs from the carry out of it.
  assign res_d.s    = sum;
  assign res_d.cout = c[WIDTH];
  assign res_d.ovfl = c[WIDTH-1] ^ c[WIDTH];

  assign bus.s    = res_d.s;
  assign bus.cout = res_d.cout;
  assign bus.ovfl = res_d.ovfl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.s_q    = res_q.s;
  assign bus.cout_q = res_q.cout;
  assign bus.ovfl_q = res_q.ovfl;

  // The group terms must reproduce the lookahead carry out for any carry in.
  a_group_terms : assert property (@(posedge clk) res_d.cout == (g_grp | (p_grp & bus.cin)));

endmodule

// File: tb/tb_adder_cla_4bit.sv
// Self-checking bench for adder_cla_4bit: exhaustive, directed corner, random and registered-path checks.
// Expected values come from integer arithmetic on the operands, never from the carry equations.
module tb_adder_cla_4bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  adder_cla_4bit_if bus_if ();

  adder_cla_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned 5-bit total, and signed range test on sign-extended operands.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int unsigned total;
    int          sa;
    int          sb;
    int          ssum;
    logic        ov;
    total = int'(a) + int'(b) + int'(cin);
    sa    = a[3] ? int'(a) - 16 : int'(a);
    sb    = b[3] ? int'(b) - 16 : int'(b);
    ssum  = sa + sb + int'(cin);
    ov    = (ssum > 7) || (ssum < -8);
    return {ov, total[4], total[3:0]};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus_if.a   = a;
    bus_if.b   = b;
    bus_if.cin = cin;
    #1;
  endtask

  task automatic check_comb(input string tag, input logic [5:0] exp);
    check({tag, ".s"},    bus_if.s,          exp[3:0]);
    check({tag, ".cout"}, {3'b0, bus_if.cout}, {3'b0, exp[4]});
    check({tag, ".ovfl"}, {3'b0, bus_if.ovfl}, {3'b0, exp[5]});
  endtask

  task automatic check_reg(input string tag, input logic [5:0] exp);
    check({tag, ".s_q"},    bus_if.s_q,            exp[3:0]);
    check({tag, ".cout_q"}, {3'b0, bus_if.cout_q}, {3'b0, exp[4]});
    check({tag, ".ovfl_q"}, {3'b0, bus_if.ovfl_q}, {3'b0, exp[5]});
  endtask

  task automatic corner(input string tag, input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [3:0] exp_s, input logic exp_cout, input logic exp_ovfl);
    drive(a, b, cin);
    check_comb(tag, {exp_ovfl, exp_cout, exp_s});
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    logic       rr;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    drive(4'd0, 4'd0, 1'b0);

    // Reset state of the registered copy.
    @(posedge clk); #1;
    check_reg("reset", 6'b0);

    // Overflow, carry-propagate and maximum corners with hand-derived results.
    rst = 1'b0;
    corner("ovf_pos",   4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1);
    corner("ovf_neg",   4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1, 1'b1);
    corner("no_ovf_m1", 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    corner("prop_all",  4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    corner("prop_alt",  4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0);
    corner("max",       4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

    // Exhaustive sweep: combinational result now, registered copy after the next edge.
    for (int i = 0; i < 512; i++) begin
      ra = i[3:0];
      rb = i[7:4];
      rc = i[8];
      drive(ra, rb, rc);
      check_comb("exh", model(ra, rb, rc));
      @(posedge clk); #1;
      check_reg("exh_reg", model(ra, rb, rc));
    end

    // Registered path: capture, then synchronous clear with inputs held.
    drive(4'b0111, 4'b0001, 1'b0);
    @(posedge clk); #1;
    check_reg("reg_cap", {1'b1, 1'b0, 4'b1000});
    rst = 1'b1;
    #1;
    check_reg("reg_hold_until_edge", {1'b1, 1'b0, 4'b1000});
    @(posedge clk); #1;
    check_reg("reg_clear", 6'b0);
    check_comb("comb_in_reset", {1'b1, 1'b0, 4'b1000});

    // Random operands with random reset pulses.
    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 7) == 0);
      rst = rr;
      drive(ra, rb, rc);
      check_comb("rnd", model(ra, rb, rc));
      @(posedge clk); #1;
      check_reg("rnd_reg", rr ? 6'b0 : model(ra, rb, rc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
